// File: rtl/fifo_rd_pkg.sv
// fifo_rd_pkg: shared defaults and buffer-occupancy encoding for the FIFO stream reader.
`default_nettype none

package fifo_rd_pkg;

   localparam int DATA_W_DFLT = 8;
   localparam int CNT_W_DFLT  = 16;

   typedef enum logic [1:0] {
      OCC_EMPTY = 2'd0,
      OCC_ONE   = 2'd1,
      OCC_TWO   = 2'd2
   } occ_e;

endpackage

`default_nettype wire

// File: rtl/fifo_skid_buf.sv
// fifo_skid_buf: two-entry output buffer; head is the word currently presented downstream.
`default_nettype none

module fifo_skid_buf
   import fifo_rd_pkg::*;
#(
   parameter int DATA_W = DATA_W_DFLT
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              capture_i,
   input  logic              pop_i,
   input  logic [DATA_W-1:0] wdata_i,
   output logic [DATA_W-1:0] head_o,
   output occ_e              occ_o
);

   occ_e              occ_q;
   logic [DATA_W-1:0] head_q;
   logic [DATA_W-1:0] tail_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         occ_q  <= OCC_EMPTY;
         head_q <= '0;
         tail_q <= '0;
      end else begin
         case (occ_q)
            OCC_EMPTY: begin
               if (capture_i) begin
                  head_q <= wdata_i;
                  occ_q  <= OCC_ONE;
               end
            end
            OCC_ONE: begin
               // Simultaneous capture and pop: the arriving word replaces the departing head.
               if (capture_i && pop_i) begin
                  head_q <= wdata_i;
               end else if (capture_i) begin
                  tail_q <= wdata_i;
                  occ_q  <= OCC_TWO;
               end else if (pop_i) begin
                  occ_q  <= OCC_EMPTY;
               end
            end
            OCC_TWO: begin
               if (pop_i) begin
                  head_q <= tail_q;
                  occ_q  <= OCC_ONE;
               end
            end
            default: occ_q <= OCC_EMPTY;
         endcase
      end
   end

   a_no_capture_when_full: assert property (
      @(posedge clk) disable iff (!rst_n) !(capture_i && (occ_q == OCC_TWO))
   );

   assign head_o = head_q;
   assign occ_o  = occ_q;

endmodule

`default_nettype wire

// File: rtl/fifo_stream_reader.sv
// fifo_stream_reader: pops sync_fifo and streams words on valid/ready, hiding the FIFO's read latency.
`default_nettype none

module fifo_stream_reader
   import fifo_rd_pkg::*;
#(
   parameter int DATA_W = DATA_W_DFLT,
   parameter int CNT_W  = CNT_W_DFLT
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              fifo_empty,
   input  logic [DATA_W-1:0] fifo_rdata,
   output logic              fifo_rinc,
   output logic              m_valid,
   input  logic              m_ready,
   output logic [DATA_W-1:0] m_data,
   input  logic              pause,
   output logic              idle,
   output logic [CNT_W-1:0]  beat_cnt
);

   occ_e             occ;
   logic             inflight_q;
   logic             pop;
   logic [2:0]       level;
   logic             room;
   logic [CNT_W-1:0] beat_cnt_q;
   logic [CNT_W-1:0] beat_cnt_d;

   fifo_skid_buf #(
      .DATA_W (DATA_W)
   ) u_buf (
      .clk       (clk),
      .rst_n     (rst_n),
      .capture_i (inflight_q),
      .pop_i     (pop),
      .wdata_i   (fifo_rdata),
      .head_o    (m_data),
      .occ_o     (occ)
   );

   assign m_valid = (occ != OCC_EMPTY);
   assign pop     = m_valid & m_ready;

   // Buffered plus in-flight words, less the one leaving now, must stay below two.
   assign level     = {1'b0, occ} + {2'b00, inflight_q};
   assign room      = (level < 3'd2) || (pop && (level == 3'd2));
   assign fifo_rinc = rst_n & ~pause & ~fifo_empty & room;

   assign beat_cnt_d = pop ? (beat_cnt_q + CNT_W'(1)) : beat_cnt_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         inflight_q <= 1'b0;
         beat_cnt_q <= '0;
      end else begin
         inflight_q <= fifo_rinc;
         beat_cnt_q <= beat_cnt_d;
      end
   end

   assign idle     = ~m_valid & ~inflight_q;
   assign beat_cnt = beat_cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_fifo_stream_reader.sv
// tb_fifo_stream_reader: directed checks of the stream reader against a behavioural sync_fifo.
`default_nettype none

module tb_fifo_stream_reader;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        pause = 1'b0;
   logic        m_ready = 1'b1;
   logic        fifo_empty;
   logic [7:0]  fifo_rdata;

   wire         fifo_rinc, m_valid, idle;
   wire  [7:0]  m_data;
   wire  [15:0] beat_cnt;
   wire         fifo_rinc4, m_valid4, idle4;
   wire  [7:0]  m_data4;
   wire  [3:0]  beat_cnt4;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   fifo_stream_reader #(.DATA_W(8), .CNT_W(16)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .fifo_empty (fifo_empty),
      .fifo_rdata (fifo_rdata),
      .fifo_rinc  (fifo_rinc),
      .m_valid    (m_valid),
      .m_ready    (m_ready),
      .m_data     (m_data),
      .pause      (pause),
      .idle       (idle),
      .beat_cnt   (beat_cnt)
   );

   // Narrow-counter copy sees identical inputs, so it tracks the same beats.
   fifo_stream_reader #(.DATA_W(8), .CNT_W(4)) dut4 (
      .clk        (clk),
      .rst_n      (rst_n),
      .fifo_empty (fifo_empty),
      .fifo_rdata (fifo_rdata),
      .fifo_rinc  (fifo_rinc4),
      .m_valid    (m_valid4),
      .m_ready    (m_ready),
      .m_data     (m_data4),
      .pause      (pause),
      .idle       (idle4),
      .beat_cnt   (beat_cnt4)
   );

   logic [7:0] mem [0:255];
   int wr_ptr = 0;
   int rd_ptr = 0;

   assign fifo_empty = (rd_ptr == wr_ptr);

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_ptr     <= wr_ptr;
         fifo_rdata <= '0;
      end else if (fifo_rinc && (rd_ptr != wr_ptr)) begin
         fifo_rdata <= mem[rd_ptr];
         rd_ptr     <= rd_ptr + 1;
      end
   end

   logic [7:0] rx [0:255];
   int rx_n = 0;

   always @(posedge clk) begin
      if (rst_n && m_valid && m_ready) begin
         rx[rx_n] <= m_data;
         rx_n     <= rx_n + 1;
      end
   end

   task automatic push(input logic [7:0] v);
      mem[wr_ptr] = v;
      wr_ptr++;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1);
   end

   initial begin
      int         base;
      logic       stall_prev;
      logic [7:0] data_prev;
      logic [3:0] pat;

      #2;
      chk("rst_rinc",  fifo_rinc, 0);
      chk("rst_valid", m_valid,   0);
      chk("rst_data",  m_data,    0);
      chk("rst_idle",  idle,      1);
      chk("rst_beat",  beat_cnt,  0);
      chk("rst_beat4", beat_cnt4, 0);

      // Single word latency
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      push(8'hAA);
      #1 chk("t1_rinc", fifo_rinc, 1);
      @(negedge clk);
      chk("t1_valid_c1", m_valid,   0);
      chk("t1_idle_c1",  idle,      0);
      chk("t1_rinc_c1",  fifo_rinc, 0);
      @(negedge clk);
      chk("t1_valid_c2", m_valid, 1);
      chk("t1_data_c2",  m_data,  8'hAA);
      @(negedge clk);
      chk("t1_valid_c3", m_valid,  0);
      chk("t1_idle_c3",  idle,     1);
      chk("t1_beat",     beat_cnt, 1);

      // Back-to-back burst
      for (int v = 1; v <= 16; v++) push(8'(v));
      #1 chk("t2_rinc", fifo_rinc, 1);
      for (int i = 1; i <= 18; i++) begin
         @(negedge clk);
         if (i == 1) begin
            chk("t2_lat_valid", m_valid, 0);
         end else if (i <= 17) begin
            chk("t2_valid", m_valid, 1);
            chk("t2_data",  m_data,  i - 1);
         end else begin
            chk("t2_end_valid", m_valid, 0);
         end
      end
      chk("t2_beat",  beat_cnt,  17);
      chk("t2_beat4", beat_cnt4, 1);
      chk("t2_idle",  idle,      1);

      // Backpressure 1,0,0,1
      base       = rx_n;
      pat        = 4'b1001;
      stall_prev = 1'b0;
      data_prev  = '0;
      for (int v = 0; v < 16; v++) push(8'h31 + 8'(v));
      for (int c = 0; c < 70; c++) begin
         @(negedge clk);
         if (stall_prev) chk("t3_stable", m_data, data_prev);
         m_ready = pat[c % 4];
         #1;
         stall_prev = m_valid & ~m_ready;
         data_prev  = m_data;
      end
      m_ready = 1'b1;
      repeat (3) @(negedge clk);
      chk("t3_count", rx_n - base, 16);
      for (int k = 0; k < 16; k++) chk("t3_order", rx[base + k], 8'h31 + 8'(k));
      chk("t3_beat",  beat_cnt,  33);
      chk("t3_beat4", beat_cnt4, 1);

      // Pause with a read in flight
      push(8'h21);
      push(8'h22);
      push(8'h23);
      #1 chk("t4_rinc0", fifo_rinc, 1);
      @(negedge clk);
      pause = 1'b1;
      #1 chk("t4_rinc_paused", fifo_rinc, 0);
      @(negedge clk);
      chk("t4_valid", m_valid,   1);
      chk("t4_data",  m_data,    8'h21);
      chk("t4_rinc1", fifo_rinc, 0);
      @(negedge clk);
      chk("t4_valid_drain", m_valid,   0);
      chk("t4_idle_drain",  idle,      1);
      chk("t4_rinc2",       fifo_rinc, 0);
      @(negedge clk);
      chk("t4_idle_hold", idle,      1);
      chk("t4_rinc3",     fifo_rinc, 0);
      pause = 1'b0;
      #1 chk("t4_resume", fifo_rinc, 1);
      @(negedge clk);
      chk("t4_lat_valid", m_valid, 0);
      @(negedge clk);
      chk("t4_valid22", m_valid, 1);
      chk("t4_data22",  m_data,  8'h22);
      @(negedge clk);
      chk("t4_valid23", m_valid, 1);
      chk("t4_data23",  m_data,  8'h23);
      @(negedge clk);
      chk("t4_idle_end", idle,     1);
      chk("t4_beat",     beat_cnt, 36);

      // Reset mid-operation
      m_ready = 1'b0;
      for (int v = 0; v < 5; v++) push(8'h51 + 8'(v));
      repeat (4) @(negedge clk);
      chk("t5_valid_full", m_valid, 1);
      chk("t5_data_full",  m_data,  8'h51);
      m_ready = 1'b1;
      #1 chk("t5_rinc_pop", fifo_rinc, 1);
      rst_n = 1'b0;
      #1;
      chk("t5_rst_valid", m_valid,   0);
      chk("t5_rst_beat",  beat_cnt,  0);
      chk("t5_rst_beat4", beat_cnt4, 0);
      chk("t5_rst_idle",  idle,      1);
      chk("t5_rst_data",  m_data,    0);
      chk("t5_rst_rinc",  fifo_rinc, 0);
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         chk("t5_no_stale_valid", m_valid,   0);
         chk("t5_no_stale_rinc",  fifo_rinc, 0);
         chk("t5_beat_hold",      beat_cnt,  0);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
